// File: rtl/fas_pkg.sv
// Shared types and constants for the FAS pipeline (FIR -> frame controller -> FFT).
package fas_pkg;

  localparam int FAS_FRAME_LEN = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } fas_ctrl_state_t;

  typedef logic fas_bank_t;

  typedef logic signed [15:0] fas_sample_t;

endpackage

// File: rtl/fas_pingpong_buf.sv
// Two-bank frame buffer: one write port, one registered read port, bank select on each.
module fas_pingpong_buf
  import fas_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic        wr_bank,
  input  logic [3:0]  wr_addr,
  input  logic [15:0] wr_data,
  input  logic        rd_bank,
  input  logic [3:0]  rd_addr,
  output logic [15:0] rd_data
);

  fas_sample_t mem [2][FAS_FRAME_LEN];

  // Storage carries no reset; contents are meaningless until a frame is written.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_bank][wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data <= '0;
    end else begin
      rd_data <= mem[rd_bank][rd_addr];
    end
  end

endmodule

// File: rtl/fas_frame_ctrl.sv
// Frame controller: packs FIR samples into ping-pong frames and hands each full frame to the FFT.
//   state    | meaning
//   ST_IDLE  | waiting for start, samples ignored
//   ST_RUN   | collecting frames, launching FFT
//   ST_DRAIN | all frames written, waiting for FFT to finish them
//   ST_DONE  | run complete, held until reset
module fas_frame_ctrl
  import fas_pkg::*;
#(
  parameter int FRAME_LEN  = 16,
  parameter int NUM_FRAMES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        fir_valid,
  input  logic [15:0] fir_d,
  output logic        fft_start,
  output logic        fft_bank,
  input  logic        fft_done,
  input  logic [3:0]  fft_rd_addr,
  output logic [15:0] fft_rd_data,
  output logic [7:0]  frame_idx,
  output logic        overflow,
  output logic [7:0]  drop_cnt,
  output logic        done
);

  localparam logic [3:0] WR_LAST    = 4'(FRAME_LEN - 1);
  localparam logic [7:0] LAST_FRAME = 8'(NUM_FRAMES - 1);

  fas_ctrl_state_t state, state_nx;
  fas_bank_t       wr_bank, rd_bank;
  logic [3:0]      wr_cnt;
  logic [1:0]      full;
  logic            busy;
  logic [7:0]      fill_cnt;

  logic accept, wr_en, drop, frame_fill, release_ev, launch;

  // Full check deliberately uses the registered value, so a sample landing on
  // the cycle its bank is released is still dropped.
  assign accept     = (state == ST_RUN) && fir_valid;
  assign wr_en      = accept && !full[wr_bank];
  assign drop       = accept && full[wr_bank];
  assign frame_fill = wr_en && (wr_cnt == WR_LAST);
  assign release_ev = fft_done && busy;
  assign launch     = !busy && full[rd_bank];

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (start) state_nx = ST_RUN;
      ST_RUN:   if (frame_fill && (fill_cnt == LAST_FRAME)) state_nx = ST_DRAIN;
      ST_DRAIN: if (release_ev && (frame_idx == LAST_FRAME)) state_nx = ST_DONE;
      ST_DONE:  state_nx = ST_DONE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_bank   <= 1'b0;
      rd_bank   <= 1'b0;
      wr_cnt    <= '0;
      full      <= '0;
      busy      <= 1'b0;
      fill_cnt  <= '0;
      frame_idx <= '0;
      overflow  <= 1'b0;
      drop_cnt  <= '0;
    end else begin
      if (wr_en) begin
        wr_cnt <= frame_fill ? 4'd0 : wr_cnt + 4'd1;
      end
      // A fill and a release always target different banks, so both may apply.
      if (frame_fill) begin
        full[wr_bank] <= 1'b1;
        wr_bank       <= ~wr_bank;
        fill_cnt      <= fill_cnt + 8'd1;
      end
      if (release_ev) begin
        full[rd_bank] <= 1'b0;
        rd_bank       <= ~rd_bank;
        busy          <= 1'b0;
        frame_idx     <= frame_idx + 8'd1;
      end else if (launch) begin
        busy <= 1'b1;
      end
      if (drop) begin
        overflow <= 1'b1;
        if (drop_cnt != 8'hff) drop_cnt <= drop_cnt + 8'd1;
      end
    end
  end

  assign fft_start = launch;
  assign fft_bank  = rd_bank;
  assign done      = (state == ST_DONE);

  fas_pingpong_buf u_buf (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_bank (wr_bank),
    .wr_addr (wr_cnt),
    .wr_data (fir_d),
    .rd_bank (rd_bank),
    .rd_addr (fft_rd_addr),
    .rd_data (fft_rd_data)
  );

endmodule

// File: tb/tb_fas_frame_ctrl.sv
// Bench for fas_frame_ctrl: frame-queue reference model plus directed and random sequences.
module tb_fas_frame_ctrl;

  localparam int NUM = 4;
  localparam int P_IDLE = 0, P_RUN = 1, P_DRAIN = 2, P_DONE = 3;

  logic        clk = 1'b0;
  logic        rst, start, fir_valid, fft_done;
  logic [15:0] fir_d;
  logic [3:0]  fft_rd_addr;
  logic        fft_start, fft_bank, overflow, done;
  logic [15:0] fft_rd_data;
  logic [7:0]  frame_idx, drop_cnt;

  always #5 clk = ~clk;

  fas_frame_ctrl #(.FRAME_LEN(16), .NUM_FRAMES(NUM)) dut (
    .clk(clk), .rst(rst), .start(start), .fir_valid(fir_valid), .fir_d(fir_d),
    .fft_start(fft_start), .fft_bank(fft_bank), .fft_done(fft_done),
    .fft_rd_addr(fft_rd_addr), .fft_rd_data(fft_rd_data), .frame_idx(frame_idx),
    .overflow(overflow), .drop_cnt(drop_cnt), .done(done)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a partial frame plus a queue of complete frames awaiting or in FFT.
  typedef struct { logic [15:0] s [16]; } frame_t;
  frame_t      frames[$];
  logic [15:0] cur[$];
  int          m_phase, m_idx, m_filled, m_drops, m_age;
  bit          m_busy, m_ovf, m_rd_valid;
  logic [15:0] m_rd_exp;

  int ag_dly = 1000;
  bit ag_spur = 0;
  bit force_done = 0;

  task automatic m_reset();
    frames.delete(); cur.delete();
    m_phase = P_IDLE; m_idx = 0; m_filled = 0; m_drops = 0; m_age = 0;
    m_busy = 0; m_ovf = 0; m_rd_valid = 0; m_rd_exp = '0;
  endtask

  task automatic model_check();
    chk("fft_start", fft_start, (!m_busy && frames.size() > 0));
    chk("fft_bank", fft_bank, m_idx % 2);
    chk("frame_idx", frame_idx, m_idx);
    chk("overflow", overflow, m_ovf);
    chk("drop_cnt", drop_cnt, (m_drops > 255) ? 255 : m_drops);
    chk("done", done, m_phase == P_DONE);
    if (m_rd_valid) chk("rd_data", fft_rd_data, m_rd_exp);
  endtask

  task automatic model_update();
    bit launch, rel, acc, drp;
    int pre;
    frame_t f;
    if (rst) begin
      m_reset();
      return;
    end
    pre    = m_phase;
    launch = !m_busy && frames.size() > 0;
    rel    = fft_done && m_busy;
    m_rd_valid = frames.size() > 0;
    if (m_rd_valid) m_rd_exp = frames[0].s[fft_rd_addr];
    acc = (pre == P_RUN) && fir_valid;
    drp = acc && frames.size() == 2;
    if (drp) begin
      m_ovf = 1;
      m_drops++;
    end
    if (rel) begin
      void'(frames.pop_front());
      m_idx++;
      m_busy = 0;
      if (pre == P_DRAIN && m_idx == NUM) m_phase = P_DONE;
    end
    if (acc && !drp) begin
      cur.push_back(fir_d);
      if (cur.size() == 16) begin
        for (int i = 0; i < 16; i++) f.s[i] = cur[i];
        frames.push_back(f);
        cur.delete();
        m_filled++;
        if (m_filled == NUM) m_phase = P_DRAIN;
      end
    end
    if (launch) begin
      m_busy = 1;
      m_age  = 1;
    end else if (m_busy) begin
      m_age++;
    end
    if (pre == P_IDLE && start) m_phase = P_RUN;
  endtask

  // FFT agent acts on the model's view of the handshake; outputs checked at negedge.
  task automatic tick();
    fft_done = force_done || (m_busy && m_age >= ag_dly) ||
               (ag_spur && !m_busy && $urandom_range(0, 7) == 0);
    @(negedge clk);
    model_check();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_run();
    rst = 1; start = 0; fir_valid = 0; force_done = 0;
    tick();
    rst = 0; start = 1;
    tick();
    start = 0;
  endtask

  typedef struct {
    bit rst, start, valid, fdone;
    logic [15:0] d;
    logic e_start;
    logic [7:0] e_idx, e_drop;
    logic e_done;
  } vec_t;
  vec_t tbl[6];

  int n_starts;
  int banks[$];

  initial begin
    rst = 1; start = 0; fir_valid = 0; fir_d = '0; fft_done = 0; fft_rd_addr = '0;
    m_reset();
    @(posedge clk);
    #1;

    // Reset values and gating before start.
    tbl[0] = '{1, 0, 0, 0, 16'h0000, 0, 0, 0, 0};
    tbl[1] = '{0, 0, 1, 0, 16'h1234, 0, 0, 0, 0};
    tbl[2] = '{0, 0, 1, 0, 16'h5678, 0, 0, 0, 0};
    tbl[3] = '{0, 0, 0, 1, 16'h0000, 0, 0, 0, 0};
    tbl[4] = '{0, 0, 1, 1, 16'h9abc, 0, 0, 0, 0};
    tbl[5] = '{0, 1, 0, 0, 16'h0000, 0, 0, 0, 0};
    for (int i = 0; i < 6; i++) begin
      rst = tbl[i].rst; start = tbl[i].start; fir_valid = tbl[i].valid;
      fir_d = tbl[i].d; force_done = tbl[i].fdone;
      tick();
      chk("tbl_start", fft_start, tbl[i].e_start);
      chk("tbl_idx", frame_idx, tbl[i].e_idx);
      chk("tbl_drop", drop_cnt, tbl[i].e_drop);
      chk("tbl_done", done, tbl[i].e_done);
      if (tbl[i].rst) chk("tbl_rd_rst", fft_rd_data, 16'h0);
    end
    start = 0; force_done = 0;

    // Single frame 0..15, launch latency, read-back, completion.
    for (int i = 0; i < 16; i++) begin
      fir_valid = 1; fir_d = 16'(i);
      tick();
    end
    fir_valid = 0;
    chk("single_start", fft_start, 1);
    chk("single_bank", fft_bank, 0);
    for (int a = 0; a < 16; a++) begin
      fft_rd_addr = 4'(a);
      tick();
      chk("single_rd", fft_rd_data, a);
    end
    ag_dly = 1;
    tick();
    chk("single_idx", frame_idx, 1);

    // Back-to-back run, FFT done 10 cycles after start.
    ag_dly = 10;
    reset_run();
    n_starts = 0; banks.delete();
    for (int i = 0; i < 64; i++) begin
      fir_valid = 1; fir_d = 16'($urandom);
      tick();
      if (fft_start) begin n_starts++; banks.push_back(fft_bank); end
    end
    fir_valid = 0;
    for (int i = 0; i < 100 && !done; i++) begin
      tick();
      if (fft_start) begin n_starts++; banks.push_back(fft_bank); end
    end
    chk("b2b_starts", n_starts, 4);
    for (int i = 0; i < 4 && i < banks.size(); i++) chk("b2b_bank", banks[i], i % 2);
    chk("b2b_ovf", overflow, 0);
    chk("b2b_done", done, 1);
    // Gating after done.
    for (int i = 0; i < 8; i++) begin
      fir_valid = 1; fir_d = 16'(i); force_done = (i < 2);
      tick();
    end
    fir_valid = 0; force_done = 0;
    chk("post_done_drop", drop_cnt, 0);
    chk("post_done_idx", frame_idx, NUM);
    chk("post_done_done", done, 1);

    // Overrun: FFT holds bank 0 for 40 cycles.
    ag_dly = 40;
    reset_run();
    for (int i = 0; i < 48; i++) begin
      fir_valid = 1; fir_d = 16'(i + 1);
      fft_rd_addr = (i >= 32) ? 4'(i - 32) : 4'd0;
      tick();
      if (i >= 32) chk("ovr_rd", fft_rd_data, i - 31);
    end
    fir_valid = 0;
    chk("ovr_drop", drop_cnt, 16);
    chk("ovr_ovf", overflow, 1);

    // Release of bank 0 coincides with fill of bank 1.
    ag_dly = 15;
    reset_run();
    for (int i = 0; i < 32; i++) begin
      fir_valid = 1; fir_d = 16'(i);
      tick();
    end
    chk("same_start", fft_start, 1);
    chk("same_bank", fft_bank, 1);
    chk("same_idx", frame_idx, 1);
    for (int i = 0; i < 7; i++) begin
      fir_d = 16'(200 + i);
      tick();
    end
    chk("same_drop", drop_cnt, 0);

    // Reset mid-run, then a fresh run.
    fir_valid = 0; rst = 1;
    tick();
    rst = 0;
    chk("rst_start", fft_start, 0);
    chk("rst_bank", fft_bank, 0);
    chk("rst_rd", fft_rd_data, 0);
    chk("rst_idx", frame_idx, 0);
    chk("rst_done", done, 0);
    ag_dly = 1000;
    start = 1;
    tick();
    start = 0;
    for (int i = 0; i < 16; i++) begin
      fir_valid = 1; fir_d = 16'(100 + i);
      tick();
    end
    fir_valid = 0;
    chk("fresh_start", fft_start, 1);
    chk("fresh_bank", fft_bank, 0);
    fft_rd_addr = 4'd3;
    tick();
    chk("fresh_rd", fft_rd_data, 103);

    // Drop counter saturation.
    reset_run();
    for (int i = 0; i < 332; i++) begin
      fir_valid = 1; fir_d = 16'(i);
      tick();
    end
    fir_valid = 0;
    chk("sat_drop", drop_cnt, 255);

    // Random traffic against the model.
    for (int r = 0; r < 8; r++) begin
      ag_dly = $urandom_range(3, 30);
      ag_spur = 1;
      reset_run();
      for (int c = 0; c < 600; c++) begin
        fir_valid   = ($urandom_range(0, 3) != 0);
        fir_d       = 16'($urandom);
        fft_rd_addr = 4'($urandom);
        start       = ($urandom_range(0, 49) == 0);
        rst         = ($urandom_range(0, 399) == 0);
        tick();
      end
      rst = 0; start = 0; fir_valid = 0;
      ag_spur = 0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
